// File: rtl/bus_pkg.sv
// Shared definitions for the bus move engine: default width, sequencer states
// and command opcode encoding.
package bus_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MV   = 3'd1,
    SW_A = 3'd2,
    SW_B = 3'd3,
    SW_C = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic OP_MOVE = 1'b0;
  localparam logic OP_SWAP = 1'b1;

endpackage

// File: rtl/bus_reg_bank.sv
// Bus-attached register bank: one write port, two combinational read ports.
// Out-of-range indices read as zero and are ignored on write.
module bus_reg_bank
  import bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = 2,
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] ra_idx,
  output logic [WIDTH-1:0] ra_data,
  input  logic [IDX_W-1:0] rb_idx,
  output logic [WIDTH-1:0] rb_data
);

  logic [WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (int'(widx) < NREG)) begin
      regs[widx] <= wdata;
    end
  end

  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (int'(ra_idx) < NREG) ra_data = regs[ra_idx];
    if (int'(rb_idx) < NREG) rb_data = regs[rb_idx];
  end

endmodule

// File: rtl/bus_move_engine.sv
// MOVE/SWAP sequencer driving the shared bus one transfer per cycle, with a
// direct preload port and a combinational observation port on the register bank.
module bus_move_engine
  import bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = 2,
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_from,
  input  logic [IDX_W-1:0] cmd_to,
  input  logic             cmd_swap,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_active,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [IDX_W-1:0] from_q, to_q;
  logic [WIDTH-1:0] tmp;
  logic             err_q;
  logic             hs, bad;
  logic             seq_we, bank_we;
  logic [IDX_W-1:0] seq_idx, src_idx, bank_idx;
  logic [WIDTH-1:0] src_data, bank_data;

  assign cmd_ready = (state == IDLE);
  assign hs        = cmd_valid && cmd_ready;
  assign bad       = (int'(cmd_from) >= NREG) || (int'(cmd_to) >= NREG);
  assign src_idx   = (state == SW_B) ? to_q : from_q;
  assign done      = (state == DONE);
  assign err       = done && err_q;

  always_comb begin
    bus_data   = '0;
    bus_active = 1'b0;
    seq_we     = 1'b0;
    seq_idx    = to_q;
    case (state)
      MV: begin
        bus_data   = src_data;
        bus_active = 1'b1;
        seq_we     = 1'b1;
      end
      SW_A: begin
        bus_data   = src_data;
        bus_active = 1'b1;
      end
      SW_B: begin
        bus_data   = src_data;
        bus_active = 1'b1;
        seq_we     = 1'b1;
        seq_idx    = from_q;
      end
      SW_C: begin
        bus_data   = tmp;
        bus_active = 1'b1;
        seq_we     = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer writes never occur in IDLE, so the direct port only competes there.
  assign bank_we   = seq_we || (cmd_ready && wr_en);
  assign bank_idx  = seq_we ? seq_idx : wr_idx;
  assign bank_data = seq_we ? bus_data : wr_data;

  bus_reg_bank #(.WIDTH(WIDTH), .NREG(NREG)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (bank_we),
    .widx   (bank_idx),
    .wdata  (bank_data),
    .ra_idx (src_idx),
    .ra_data(src_data),
    .rb_idx (rd_idx),
    .rb_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      from_q <= '0;
      to_q   <= '0;
      tmp    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            from_q <= cmd_from;
            to_q   <= cmd_to;
            err_q  <= bad;
            if (bad)                    state <= DONE;
            else if (cmd_swap == OP_SWAP) state <= SW_A;
            else                        state <= MV;
          end
        end
        MV:   state <= DONE;
        SW_A: begin
          tmp   <= bus_data;
          state <= SW_B;
        end
        SW_B: state <= SW_C;
        SW_C: state <= DONE;
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_move_engine.sv
// Bench for bus_move_engine: directed scenarios plus randomized commands checked
// against an array model of the register file.
module tb_bus_move_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_from = 1'b0, cmd_to = 1'b0, cmd_swap = 1'b0;
  logic       wr_en = 1'b0, wr_idx = 1'b0, rd_idx = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       cmd_ready, bus_active, done, err;
  logic [7:0] rd_data, bus_data;

  logic       e_cmd_valid = 1'b0, e_cmd_swap = 1'b0, e_wr_en = 1'b0;
  logic [1:0] e_cmd_from = 2'd0, e_cmd_to = 2'd0, e_wr_idx = 2'd0, e_rd_idx = 2'd0;
  logic [7:0] e_wr_data = 8'h00;
  logic       e_cmd_ready, e_bus_active, e_done, e_err;
  logic [7:0] e_rd_data, e_bus_data;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m [2];

  always #5 clk = ~clk;

  bus_move_engine #(.WIDTH(8), .NREG(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_from(cmd_from), .cmd_to(cmd_to), .cmd_swap(cmd_swap),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .bus_data(bus_data),
    .bus_active(bus_active), .done(done), .err(err)
  );

  bus_move_engine #(.WIDTH(8), .NREG(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(e_cmd_valid), .cmd_ready(e_cmd_ready),
    .cmd_from(e_cmd_from), .cmd_to(e_cmd_to), .cmd_swap(e_cmd_swap),
    .wr_en(e_wr_en), .wr_idx(e_wr_idx), .wr_data(e_wr_data),
    .rd_idx(e_rd_idx), .rd_data(e_rd_data), .bus_data(e_bus_data),
    .bus_active(e_bus_active), .done(e_done), .err(e_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic i, input logic [7:0] v);
    wr_en = 1'b1; wr_idx = i; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic e_wr(input logic [1:0] i, input logic [7:0] v);
    e_wr_en = 1'b1; e_wr_idx = i; e_wr_data = v;
    tick();
    e_wr_en = 1'b0;
  endtask

  task automatic peek(input logic i, output logic [7:0] v);
    rd_idx = i;
    #1;
    v = rd_data;
  endtask

  task automatic e_peek(input logic [1:0] i, output logic [7:0] v);
    e_rd_idx = i;
    #1;
    v = e_rd_data;
  endtask

  // Presents one command during the handshake cycle and returns in cycle 1.
  task automatic issue(input logic f, input logic t, input logic s);
    cmd_valid = 1'b1; cmd_from = f; cmd_to = t; cmd_swap = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      peek(1'(i), v);
      vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d got %h want 00", i, v); end
    end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (bus_active !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b want 0", bus_active); end
    vectors++; if (bus_data !== 8'h00) begin miscompares++; $display("FAIL reset_bus got %h want 00", bus_data); end
  endtask

  task automatic test_move();
    logic [7:0] v;
    wr(1'b0, 8'h05); wr(1'b1, 8'h10);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL move_ready0 got %b want 1", cmd_ready); end
    issue(1'b0, 1'b1, 1'b0);
    vectors++; if (bus_data !== 8'h05 || bus_active !== 1'b1) begin miscompares++; $display("FAIL move_bus got %h/%b want 05/1", bus_data, bus_active); end
    vectors++; if (cmd_ready !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL move_c1_ctl got ready %b done %b want 0 0", cmd_ready, done); end
    tick();
    vectors++; if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b0 || bus_active !== 1'b0) begin
      miscompares++; $display("FAIL move_done got done %b err %b ready %b act %b want 1 0 0 0", done, err, cmd_ready, bus_active);
    end
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL move_idle got done %b ready %b want 0 1", done, cmd_ready); end
    peek(1'b1, v);
    vectors++; if (v !== 8'h05) begin miscompares++; $display("FAIL move_reg1 got %h want 05", v); end
    peek(1'b0, v);
    vectors++; if (v !== 8'h05) begin miscompares++; $display("FAIL move_reg0 got %h want 05", v); end
  endtask

  task automatic test_swap();
    logic [7:0] v;
    logic [7:0] exp [3];
    exp[0] = 8'hFF; exp[1] = 8'hF0; exp[2] = 8'hFF;
    wr(1'b0, 8'hFF); wr(1'b1, 8'hF0);
    issue(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (bus_data !== exp[k] || bus_active !== 1'b1 || done !== 1'b0) begin
        miscompares++; $display("FAIL swap_bus%0d got %h/%b done %b want %h/1 0", k, bus_data, bus_active, done, exp[k]);
      end
      tick();
    end
    vectors++; if (done !== 1'b1 || bus_active !== 1'b0) begin miscompares++; $display("FAIL swap_done got %b/%b want 1/0", done, bus_active); end
    tick();
    peek(1'b0, v);
    vectors++; if (v !== 8'hF0) begin miscompares++; $display("FAIL swap_reg0 got %h want f0", v); end
    peek(1'b1, v);
    vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL swap_reg1 got %h want ff", v); end
  endtask

  task automatic test_write_drop();
    logic [7:0] v;
    wr(1'b0, 8'h33); wr(1'b1, 8'h00);
    issue(1'b0, 1'b1, 1'b0);
    wr_en = 1'b1; wr_idx = 1'b0; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tick();
    peek(1'b0, v);
    vectors++; if (v !== 8'h33) begin miscompares++; $display("FAIL drop_reg0 got %h want 33", v); end
    peek(1'b1, v);
    vectors++; if (v !== 8'h33) begin miscompares++; $display("FAIL drop_reg1 got %h want 33", v); end
    wr_en = 1'b1; wr_idx = 1'b0; wr_data = 8'h08;
    issue(1'b0, 1'b1, 1'b0);
    wr_en = 1'b0;
    vectors++; if (bus_data !== 8'h08) begin miscompares++; $display("FAIL samecyc_bus got %h want 08", bus_data); end
    tick(); tick();
    peek(1'b1, v);
    vectors++; if (v !== 8'h08) begin miscompares++; $display("FAIL samecyc_reg1 got %h want 08", v); end
  endtask

  task automatic test_back_to_back();
    wr(1'b0, 8'h21); wr(1'b1, 8'h42);
    cmd_valid = 1'b1; cmd_from = 1'b0; cmd_to = 1'b1; cmd_swap = 1'b0;
    tick();
    vectors++; if (cmd_ready !== 1'b0 || bus_data !== 8'h21) begin miscompares++; $display("FAIL b2b_mv got ready %b bus %h want 0 21", cmd_ready, bus_data); end
    tick();
    vectors++; if (cmd_ready !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL b2b_done got ready %b done %b want 0 1", cmd_ready, done); end
    tick();
    vectors++; if (cmd_ready !== 1'b1 || bus_active !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got ready %b act %b want 1 0", cmd_ready, bus_active); end
    cmd_from = 1'b1; cmd_to = 1'b0;
    tick();
    cmd_valid = 1'b0;
    vectors++; if (bus_active !== 1'b1 || bus_data !== 8'h21) begin miscompares++; $display("FAIL b2b_second got %b/%h want 1/21", bus_active, bus_data); end
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_same_idx();
    logic [7:0] v;
    wr(1'b1, 8'h02);
    issue(1'b1, 1'b1, 1'b0);
    vectors++; if (bus_data !== 8'h02) begin miscompares++; $display("FAIL same_bus got %h want 02", bus_data); end
    tick();
    vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL same_done got %b err %b want 1 0", done, err); end
    tick();
    peek(1'b1, v);
    vectors++; if (v !== 8'h02) begin miscompares++; $display("FAIL same_reg1 got %h want 02", v); end
  endtask

  task automatic test_reset_mid_swap();
    logic [7:0] v;
    wr(1'b0, 8'hAA); wr(1'b1, 8'h55);
    issue(1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (cmd_ready !== 1'b1 || bus_active !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL midrst_ctl got ready %b act %b done %b want 1 0 0", cmd_ready, bus_active, done);
    end
    peek(1'b0, v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL midrst_reg0 got %h want 00", v); end
    peek(1'b1, v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL midrst_reg1 got %h want 00", v); end
    tick();
    vectors++; if (bus_active !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_stay got act %b done %b want 0 0", bus_active, done); end
  endtask

  task automatic test_err();
    logic [7:0] v;
    logic [7:0] pre [3];
    pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33;
    for (int i = 0; i < 3; i++) e_wr(2'(i), pre[i]);
    for (int c = 0; c < 2; c++) begin
      e_cmd_valid = 1'b1; e_cmd_swap = 1'(c);
      e_cmd_from = (c == 0) ? 2'd3 : 2'd1;
      e_cmd_to   = (c == 0) ? 2'd0 : 2'd3;
      tick();
      e_cmd_valid = 1'b0;
      vectors++; if (e_done !== 1'b1 || e_err !== 1'b1 || e_bus_active !== 1'b0) begin
        miscompares++; $display("FAIL err%0d_c1 got done %b err %b act %b want 1 1 0", c, e_done, e_err, e_bus_active);
      end
      tick();
      vectors++; if (e_done !== 1'b0 || e_err !== 1'b0 || e_cmd_ready !== 1'b1) begin
        miscompares++; $display("FAIL err%0d_c2 got done %b err %b ready %b want 0 0 1", c, e_done, e_err, e_cmd_ready);
      end
    end
    for (int i = 0; i < 3; i++) begin
      e_peek(2'(i), v);
      vectors++; if (v !== pre[i]) begin miscompares++; $display("FAIL err_reg%0d got %h want %h", i, v, pre[i]); end
    end
    e_peek(2'd3, v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL err_rd3 got %h want 00", v); end
    e_cmd_valid = 1'b1; e_cmd_from = 2'd2; e_cmd_to = 2'd0; e_cmd_swap = 1'b0;
    tick();
    e_cmd_valid = 1'b0;
    vectors++; if (e_bus_data !== 8'h33 || e_bus_active !== 1'b1) begin miscompares++; $display("FAIL n3_move_bus got %h/%b want 33/1", e_bus_data, e_bus_active); end
    tick();
    vectors++; if (e_done !== 1'b1 || e_err !== 1'b0) begin miscompares++; $display("FAIL n3_move_done got %b err %b want 1 0", e_done, e_err); end
    tick();
    e_peek(2'd0, v);
    vectors++; if (v !== 8'h33) begin miscompares++; $display("FAIL n3_move_reg0 got %h want 33", v); end
  endtask

  task automatic test_random();
    logic [7:0] v, t8;
    logic       f, t, s, wi;
    logic [7:0] wv;
    logic [7:0] exp [$];
    m[0] = 8'($urandom); m[1] = 8'($urandom);
    wr(1'b0, m[0]); wr(1'b1, m[1]);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wi = 1'($urandom_range(0, 1)); wv = 8'($urandom);
        wr(wi, wv);
        m[wi] = wv;
      end else begin
        f = 1'($urandom_range(0, 1)); t = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          wi = 1'($urandom_range(0, 1)); wv = 8'($urandom);
          wr_en = 1'b1; wr_idx = wi; wr_data = wv;
          m[wi] = wv;
        end
        exp.delete();
        exp.push_back(m[f]);
        if (s) begin exp.push_back(m[t]); exp.push_back(m[f]); end
        issue(f, t, s);
        wr_en = 1'b0;
        foreach (exp[k]) begin
          vectors++; if (bus_active !== 1'b1 || bus_data !== exp[k]) begin
            miscompares++; $display("FAIL rnd%0d_bus%0d got %b/%h want 1/%h", n, k, bus_active, bus_data, exp[k]);
          end
          tick();
        end
        vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_done got %b err %b want 1 0", n, done, err); end
        if (s) begin t8 = m[f]; m[f] = m[t]; m[t] = t8; end
        else m[t] = m[f];
        tick();
        for (int i = 0; i < 2; i++) begin
          peek(1'(i), v);
          vectors++; if (v !== m[i]) begin miscompares++; $display("FAIL rnd%0d_reg%0d got %h want %h", n, i, v, m[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_swap();
    test_write_drop();
    test_back_to_back();
    test_same_idx();
    test_reset_mid_swap();
    test_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
